// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and the parity helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   // Widest word the parity helper accepts; narrower words are zero-extended.
   localparam int UART_MAX_W = 32;

   // Expected parity bit: even parity is the XOR of the data, odd parity its inverse.
   function automatic logic calc_parity(input logic [UART_MAX_W-1:0] data,
                                        input logic                  odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Parallel-side and line-side signals of the UART receiver, with modports for the
// driving side (master) and the receiver itself (slave).
interface uart_rx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  rx_in;
   logic                  par_en;
   logic                  par_typ;
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;

   modport master (
      output rx_in, par_en, par_typ,
      input  p_data, data_valid, par_err, stp_err
   );

   modport slave (
      input  rx_in, par_en, par_typ,
      output p_data, data_valid, par_err, stp_err
   );
endinterface

// File: rtl/uart_rx_sampler.sv
// Bit timing for the UART receiver: edge/bit counters and the per-bit sample.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote around the bit centre instead of one sample.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE   = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            run,
   input  logic                            rx_in,
   input  logic                            cnt_data,
   output logic [$clog2(DATA_WIDTH+1)-1:0] bit_cnt,
   output logic                            sample_bit,
   output logic                            bit_done
);
   localparam int EW = $clog2(PRESCALE);
   localparam int BW = $clog2(DATA_WIDTH+1);
   localparam logic [EW-1:0] LAST = EW'(PRESCALE - 1);
   localparam logic [EW-1:0] MID  = EW'(PRESCALE / 2);

   logic [EW-1:0] edge_cnt;

   // The counter idles at 0, so the cycle a start edge is seen is edge_cnt 0 of the start bit.
   always_ff @(posedge clk) begin
      if (rst || !run || edge_cnt == LAST)
         edge_cnt <= '0;
      else
         edge_cnt <= edge_cnt + 1'b1;
   end

   assign bit_done = run && (edge_cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || !cnt_data)
         bit_cnt <= '0;
      else if (bit_done)
         bit_cnt <= bit_cnt + BW'(1);
   end

`ifdef UART_RX_MAJORITY_EN
   logic s_lo, s_mid, s_hi, s_hi_now;

   always_ff @(posedge clk) begin
      if (rst) begin
         s_lo  <= 1'b1;
         s_mid <= 1'b1;
         s_hi  <= 1'b1;
      end else begin
         if (edge_cnt == MID - 1'b1) s_lo  <= rx_in;
         if (edge_cnt == MID)        s_mid <= rx_in;
         if (edge_cnt == MID + 1'b1) s_hi  <= rx_in;
      end
   end

   // With PRESCALE = 4 the last vote lands on the bit_done cycle, so forward it.
   assign s_hi_now   = (edge_cnt == MID + 1'b1) ? rx_in : s_hi;
   assign sample_bit = (s_lo & s_mid) | (s_lo & s_hi_now) | (s_mid & s_hi_now);
`else
   logic s_mid;

   always_ff @(posedge clk) begin
      if (rst)
         s_mid <= 1'b1;
      else if (edge_cnt == MID)
         s_mid <= rx_in;
   end

   assign sample_bit = s_mid;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled frame recovery (start, data LSB first, optional parity, stop)
// with one-cycle outcome strobes. Build option UART_RX_MAJORITY_EN (see uart_rx_sampler).
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,   // must not exceed UART_MAX_W
   parameter int PRESCALE   = 8    // even, >= 4
) (
   input  logic     clk,
   input  logic     rst,
   uart_rx_if.slave bus
);
   localparam int BW = $clog2(DATA_WIDTH+1);

   uart_state_e state, state_nxt;

   logic [BW-1:0]         bit_cnt;
   logic                  sample_bit, bit_done, run;
   logic                  start_ok, shift_en, par_chk, finish;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  par_en_q, par_typ_q, perr_q;
   logic [DATA_WIDTH-1:0] p_data_q;
   logic                  data_valid_q, par_err_q, stp_err_q;

   assign run = (state != IDLE) || !bus.rx_in;

   uart_rx_sampler #(
      .DATA_WIDTH (DATA_WIDTH),
      .PRESCALE   (PRESCALE)
   ) u_sampler (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .rx_in      (bus.rx_in),
      .cnt_data   (state == DATA),
      .bit_cnt    (bit_cnt),
      .sample_bit (sample_bit),
      .bit_done   (bit_done)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (!bus.rx_in) state_nxt = START;
         START:  if (bit_done)   state_nxt = sample_bit ? IDLE : DATA;
         DATA:   if (bit_done && bit_cnt == BW'(DATA_WIDTH - 1))
                    state_nxt = par_en_q ? PARITY : STOP;
         PARITY: if (bit_done)   state_nxt = STOP;
         STOP:   if (bit_done)   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // All datapath actions happen on the last cycle of a bit, when sample_bit is settled.
   always_comb begin
      start_ok = 1'b0;
      shift_en = 1'b0;
      par_chk  = 1'b0;
      finish   = 1'b0;
      case (state)
         START:   start_ok = bit_done && !sample_bit;
         DATA:    shift_en = bit_done;
         PARITY:  par_chk  = bit_done;
         STOP:    finish   = bit_done;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q      <= '0;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         perr_q       <= 1'b0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
         // Frame configuration is latched once, so mid-frame changes cannot split a frame.
         if (start_ok) begin
            par_en_q  <= bus.par_en;
            par_typ_q <= bus.par_typ;
            perr_q    <= 1'b0;
         end
         if (shift_en)
            shift_q <= {sample_bit, shift_q[DATA_WIDTH-1:1]};
         if (par_chk)
            perr_q <= sample_bit != calc_parity(UART_MAX_W'(shift_q), par_typ_q);
         if (finish) begin
            data_valid_q <= !perr_q && sample_bit;
            par_err_q    <= perr_q;
            stp_err_q    <= !sample_bit;
            if (!perr_q && sample_bit)
               p_data_q <= shift_q;
         end
      end
   end

   assign bus.p_data     = p_data_q;
   assign bus.data_valid = data_valid_q;
   assign bus.par_err    = par_err_q;
   assign bus.stp_err    = stp_err_q;

   a_valid_clean: assert property (@(posedge clk) disable iff (rst)
      data_valid_q |-> !(par_err_q || stp_err_q));
   a_one_cycle: assert property (@(posedge clk) disable iff (rst)
      (data_valid_q || par_err_q || stp_err_q) |=> !(data_valid_q || par_err_q || stp_err_q));

endmodule
